// File: rtl/ahb_timer_slave.sv
// ----------------------------------------------------------------------------
// ahb_timer_slave
//   AHB-Lite slave wrapping a 32-bit prescaled timer with compare-match
//   interrupt. Four word registers decoded on HADDR[3:2]:
//     0 CTRL    [0] EN, [1] IRQ_EN, [2] ONESHOT, [31:16] PRESC
//     1 COMPARE match value
//     2 COUNT   running counter
//     3 STATUS  [0] MATCH, write-1-to-clear
//   Any accepted transfer with HADDR[7:4] != 0 gets a two-cycle ERROR.
//
// Ports
//   Clk, Rst            clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HWDATA   AHB slave inputs
//   HRDATA, HREADY, HRESP                 AHB slave outputs
//   irq                 registered level interrupt (MATCH & IRQ_EN)
//
// ADDR_W must be at least 9.
// ----------------------------------------------------------------------------
module ahb_timer_slave #(
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADY,
    output logic              HRESP,
    output logic              irq
);

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COMPARE = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } resp_state_t;

    resp_state_t r_state;
    resp_state_t w_state_nxt;

    // Timer registers
    logic        r_en;
    logic        r_irq_en;
    logic        r_oneshot;
    logic [15:0] r_presc;
    logic [15:0] r_presc_cnt;
    logic [31:0] r_compare;
    logic [31:0] r_count;
    logic        r_match;

    // Pending OKAY data phase
    logic        r_dp_valid;
    logic        r_dp_write;
    logic [1:0]  r_dp_reg;

    // Combinational
    logic        w_ready;
    logic        w_accept;
    logic        w_addr_err;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_compare;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_match_set;
    logic        w_en_nxt;
    logic        w_irq_en_nxt;
    logic        w_oneshot_nxt;
    logic [15:0] w_presc_nxt;
    logic [15:0] w_presc_cnt_nxt;
    logic [31:0] w_compare_nxt;
    logic [31:0] w_count_nxt;
    logic        w_match_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_load_rdata;
    logic        w_unused_bits;

    function automatic logic [31:0] reg_mux(
        input logic [1:0]  sel,
        input logic        en,
        input logic        irq_en,
        input logic        oneshot,
        input logic [15:0] presc,
        input logic [31:0] compare,
        input logic [31:0] count,
        input logic        match
    );
        logic [31:0] v;
        v = '0;
        case (sel)
            REG_CTRL:    v = {presc, 13'd0, oneshot, irq_en, en};
            REG_COMPARE: v = compare;
            REG_COUNT:   v = count;
            default:     v = {31'd0, match};
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Bus handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_ready       = (r_state != ST_ERR1);
        w_accept      = w_ready & HSEL & HTRANS[1];
        w_addr_err    = (HADDR[7:4] != 4'h0);
        w_unused_bits = ^{HADDR[ADDR_W-1:8], HADDR[1:0], HTRANS[0]};
    end

    always_comb begin
        w_state_nxt = r_state;
        HREADY      = 1'b1;
        HRESP       = 1'b0;
        case (r_state)
            ST_OKAY: begin
                if (w_accept && w_addr_err) w_state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                HREADY      = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP       = 1'b1;
                w_state_nxt = (w_accept && w_addr_err) ? ST_ERR1 : ST_OKAY;
            end
            default: w_state_nxt = ST_OKAY;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= ST_OKAY;
        else     r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // Register next-state: bus write, prescaler, counter, match
    // ------------------------------------------------------------------
    always_comb begin
        w_wr         = r_dp_valid & r_dp_write;
        w_wr_ctrl    = w_wr & (r_dp_reg == REG_CTRL);
        w_wr_compare = w_wr & (r_dp_reg == REG_COMPARE);
        w_wr_count   = w_wr & (r_dp_reg == REG_COUNT);
        w_wr_status  = w_wr & (r_dp_reg == REG_STATUS);

        w_tick      = r_en & (r_presc_cnt == r_presc);
        // A bus write to COUNT suppresses match evaluation for that tick.
        w_match_set = w_tick & ~w_wr_count & (r_count == r_compare);

        w_en_nxt      = r_en;
        w_irq_en_nxt  = r_irq_en;
        w_oneshot_nxt = r_oneshot;
        w_presc_nxt   = r_presc;
        if (w_wr_ctrl) begin
            w_en_nxt      = HWDATA[0];
            w_irq_en_nxt  = HWDATA[1];
            w_oneshot_nxt = HWDATA[2];
            w_presc_nxt   = HWDATA[31:16];
        end else if (w_match_set && r_oneshot) begin
            w_en_nxt = 1'b0;
        end

        if (!r_en || w_wr_ctrl || w_tick) w_presc_cnt_nxt = '0;
        else                              w_presc_cnt_nxt = r_presc_cnt + 16'd1;

        w_compare_nxt = w_wr_compare ? HWDATA : r_compare;

        w_count_nxt = r_count;
        if (w_wr_count)  w_count_nxt = HWDATA;
        else if (w_tick) w_count_nxt = (r_count == r_compare) ? '0 : r_count + 32'd1;

        // Set has priority over write-1-to-clear.
        w_match_nxt = r_match;
        if (w_match_set)                   w_match_nxt = 1'b1;
        else if (w_wr_status && HWDATA[0]) w_match_nxt = 1'b0;
    end

    // Read data: a read following a write to the same register sees the
    // value that write commits at this same edge.
    always_comb begin
        w_load_rdata = w_accept & (w_addr_err | ~HWRITE);
        if (w_addr_err)
            w_rdata_nxt = '0;
        else if (w_wr && (r_dp_reg == HADDR[3:2]))
            w_rdata_nxt = reg_mux(HADDR[3:2], w_en_nxt, w_irq_en_nxt, w_oneshot_nxt,
                                  w_presc_nxt, w_compare_nxt, w_count_nxt, w_match_nxt);
        else
            w_rdata_nxt = reg_mux(HADDR[3:2], r_en, r_irq_en, r_oneshot,
                                  r_presc, r_compare, r_count, r_match);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_en        <= 1'b0;
            r_irq_en    <= 1'b0;
            r_oneshot   <= 1'b0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_compare   <= RST_COMPARE;
            r_count     <= '0;
            r_match     <= 1'b0;
            r_dp_valid  <= 1'b0;
            r_dp_write  <= 1'b0;
            r_dp_reg    <= '0;
            HRDATA      <= '0;
            irq         <= 1'b0;
        end else begin
            r_en        <= w_en_nxt;
            r_irq_en    <= w_irq_en_nxt;
            r_oneshot   <= w_oneshot_nxt;
            r_presc     <= w_presc_nxt;
            r_presc_cnt <= w_presc_cnt_nxt;
            r_compare   <= w_compare_nxt;
            r_count     <= w_count_nxt;
            r_match     <= w_match_nxt;
            r_dp_valid  <= w_accept & ~w_addr_err;
            r_dp_write  <= w_accept & HWRITE;
            r_dp_reg    <= HADDR[3:2];
            if (w_load_rdata) HRDATA <= w_rdata_nxt;
            irq         <= r_match & r_irq_en;
        end
    end

endmodule

// File: tb/tb_ahb_timer_slave.sv
module tb_ahb_timer_slave;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        irq;

    typedef struct {
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb_timer_slave #(.ADDR_W(32), .RST_COMPARE(32'hFFFF_FFFF)) dut (
        .Clk(Clk), .Rst(Rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP), .irq(irq)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- bus primitives (no checking) ----------------
    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = '0;
    endtask

    task automatic finish_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Returns 1ns after the edge that commits the write.
    task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, addr};
        finish_cycle();
        bus_idle();
        HWDATA = data;
        finish_cycle();
    endtask

    // Returns at the falling edge inside the read data phase.
    task automatic read_reg(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, addr};
        sb_q.push_back('{exp, tag});
        finish_cycle();
        bus_idle();
        @(negedge Clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_r [4];
        exp_r = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        bus_idle();
        HWDATA = '0;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b0 || irq !== 1'b0 || HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got HREADY=%b HRESP=%b irq=%b HRDATA=%h, expected 1 0 0 00000000",
                     HREADY, HRESP, irq, HRDATA);
        end
        Rst = 1'b0;
        finish_cycle();
        for (int i = 0; i < 4; i++) begin
            read_reg(8'(i * 4), exp_r[i], "reset_reg");
            e = sb_q.pop_front();
            n_checks++;
            if (HRDATA !== e.data) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h expected %h", e.tag, i, HRDATA, e.data);
            end
            finish_cycle();
        end
    endtask

    task automatic test_periodic();
        logic [31:0] exp_c [8];
        exp_c = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
        write_reg(8'h04, 32'd5);
        write_reg(8'h00, 32'h0000_0003);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h08;
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back('{exp_c[k], "periodic_count"});
            @(posedge Clk);
            @(negedge Clk);
            e = sb_q.pop_front();
            n_checks++;
            if (HRDATA !== e.data || HREADY !== 1'b1) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h HREADY=%b expected %h HREADY=1", e.tag, k, HRDATA, HREADY, e.data);
            end
            n_checks++;
            if (irq !== (k >= 6)) begin
                n_fail++;
                $display("FAIL periodic_irq[%0d]: got %b expected %b", k, irq, (k >= 6));
            end
        end
        bus_idle();
        finish_cycle();
        read_reg(8'h0C, 32'h1, "periodic_status");
        e = sb_q.pop_front();
        n_checks++;
        if (HRDATA !== e.data) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.tag, HRDATA, e.data);
        end
        finish_cycle();
        write_reg(8'h00, 32'h0);
    endtask

    task automatic test_oneshot();
        logic [31:0] exp_c [10];
        exp_c = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        write_reg(8'h08, 32'h0);
        write_reg(8'h0C, 32'h1);
        write_reg(8'h04, 32'h1);
        write_reg(8'h00, 32'h0002_0005);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h08;
        for (int k = 0; k < 10; k++) begin
            sb_q.push_back('{exp_c[k], "oneshot_count"});
            @(posedge Clk);
            @(negedge Clk);
            e = sb_q.pop_front();
            n_checks++;
            if (HRDATA !== e.data) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h expected %h", e.tag, k, HRDATA, e.data);
            end
        end
        bus_idle();
        finish_cycle();
        read_reg(8'h0C, 32'h1, "oneshot_status");
        e = sb_q.pop_front();
        n_checks++;
        if (HRDATA !== e.data) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.tag, HRDATA, e.data);
        end
        finish_cycle();
        read_reg(8'h00, 32'h0002_0004, "oneshot_ctrl_en_cleared");
        e = sb_q.pop_front();
        n_checks++;
        if (HRDATA !== e.data || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got %h irq=%b expected %h irq=0", e.tag, HRDATA, irq, e.data);
        end
        finish_cycle();
    endtask

    task automatic test_error();
        logic [31:0] exp_r [3];
        logic [7:0]  adr_r [3];
        exp_r = '{32'h1, 32'h0002_0004, 32'h0};
        adr_r = '{8'h04, 8'h00, 8'h08};
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h40;
        finish_cycle();
        // Transfer presented during the first error cycle must be ignored.
        HWRITE = 1'b1; HADDR = 32'h04;
        @(negedge Clk);
        n_checks++;
        if (HREADY !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL err_cycle1: got HREADY=%b HRESP=%b HRDATA=%h expected 0 1 00000000", HREADY, HRESP, HRDATA);
        end
        finish_cycle();
        bus_idle();
        HWDATA = 32'hDEAD_BEEF;
        @(negedge Clk);
        n_checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b1 || HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL err_cycle2: got HREADY=%b HRESP=%b HRDATA=%h expected 1 1 00000000", HREADY, HRESP, HRDATA);
        end
        finish_cycle();
        @(negedge Clk);
        n_checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b0) begin
            n_fail++;
            $display("FAIL err_recover: got HREADY=%b HRESP=%b expected 1 0", HREADY, HRESP);
        end
        finish_cycle();
        write_reg(8'h44, 32'h0000_DEAD);
        finish_cycle();
        for (int i = 0; i < 3; i++) begin
            read_reg(adr_r[i], exp_r[i], "err_unchanged");
            e = sb_q.pop_front();
            n_checks++;
            if (HRDATA !== e.data) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h expected %h", e.tag, i, HRDATA, e.data);
            end
            finish_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  adr_r [2];
        logic [31:0] wd_r  [2];
        logic [31:0] exp_r [2];
        adr_r = '{8'h04, 8'h00};
        wd_r  = '{32'h0000_1234, 32'h0007_FFFE};
        exp_r = '{32'h0000_1234, 32'h0007_0006};
        for (int i = 0; i < 2; i++) begin
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, adr_r[i]};
            finish_cycle();
            HWRITE = 1'b0;
            HWDATA = wd_r[i];
            sb_q.push_back('{exp_r[i], "b2b_fwd"});
            finish_cycle();
            bus_idle();
            @(negedge Clk);
            e = sb_q.pop_front();
            n_checks++;
            if (HRDATA !== e.data || HREADY !== 1'b1 || HRESP !== 1'b0) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h HREADY=%b HRESP=%b expected %h 1 0",
                         e.tag, i, HRDATA, HREADY, HRESP, e.data);
            end
            finish_cycle();
            read_reg(adr_r[i], exp_r[i], "b2b_readback");
            e = sb_q.pop_front();
            n_checks++;
            if (HRDATA !== e.data) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h expected %h", e.tag, i, HRDATA, e.data);
            end
            finish_cycle();
        end
        write_reg(8'h00, 32'h0);
    endtask

    task automatic test_match_collision();
        write_reg(8'h08, 32'h0);
        write_reg(8'h04, 32'h1);
        write_reg(8'h0C, 32'h1);
        write_reg(8'h00, 32'h0000_0003);
        // Second tick after enable is the match; this clear lands on it.
        write_reg(8'h0C, 32'h1);
        read_reg(8'h0C, 32'h1, "collide_set_wins");
        e = sb_q.pop_front();
        n_checks++;
        if (HRDATA !== e.data) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.tag, HRDATA, e.data);
        end
        finish_cycle();
        write_reg(8'h00, 32'h0000_0002);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_irq_high: got %b expected 1", irq);
        end
        write_reg(8'h0C, 32'h1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_irq_lag: got %b expected 1", irq);
        end
        finish_cycle();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_irq_drop: got %b expected 0", irq);
        end
        read_reg(8'h0C, 32'h0, "clear_status");
        e = sb_q.pop_front();
        n_checks++;
        if (HRDATA !== e.data) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.tag, HRDATA, e.data);
        end
        finish_cycle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_r [4];
        exp_r = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        write_reg(8'h04, 32'h0);
        write_reg(8'h00, 32'h0000_0003);
        repeat (2) finish_cycle();
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_irq: got %b expected 1", irq);
        end
        write_reg(8'h00, 32'h0000_0002);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
        finish_cycle();
        bus_idle();
        HWDATA = 32'h0000_ABCD;
        #2 Rst = 1'b1;
        finish_cycle();
        n_checks++;
        if (HREADY !== 1'b1 || HRESP !== 1'b0 || irq !== 1'b0 || HRDATA !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got HREADY=%b HRESP=%b irq=%b HRDATA=%h expected 1 0 0 00000000",
                     HREADY, HRESP, irq, HRDATA);
        end
        #3 Rst = 1'b0;
        finish_cycle();
        for (int i = 0; i < 4; i++) begin
            read_reg(8'(i * 4), exp_r[i], "midrst_reg");
            e = sb_q.pop_front();
            n_checks++;
            if (HRDATA !== e.data) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %h expected %h", e.tag, i, HRDATA, e.data);
            end
            finish_cycle();
        end
    endtask

    initial begin
        Rst    = 1'b1;
        HWDATA = '0;
        bus_idle();
        test_reset();
        test_periodic();
        test_oneshot();
        test_error();
        test_back_to_back();
        test_match_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_timer_slave.md
AHB_TIMER_SLAVE -- requirements
Module: ahb_timer_slave

Interface
REQ-001 Parameter: ADDR_W, default 32, width of HADDR.
REQ-002 Parameter: RST_COMPARE, default 32'hFFFF_FFFF, reset value of COMPARE.
REQ-003 Clk  input  1  clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 HSEL  input  1  slave select from the bus decoder.
REQ-006 HADDR  input  ADDR_W  transfer address, valid in the address phase.
REQ-007 HTRANS  input  2  transfer type; bit1=1 means NONSEQ/SEQ, 2'b00 means IDLE.
REQ-008 HWRITE  input  1  1=write, 0=read; valid in the address phase.
REQ-009 HWDATA  input  32  write data, valid in the data phase (one cycle after the address phase).
REQ-010 HRDATA  output  32  read data, valid in the data phase when HREADY=1.
REQ-011 HREADY  output  1  1=data phase completes this cycle or slave idle; 0=wait/error first cycle.
REQ-012 HRESP  output  1  0=OKAY, 1=ERROR.
REQ-013 irq  output  1  timer interrupt, level, registered.

Function
REQ-014 Transfer accepted at a rising edge when HSEL=1, HTRANS[1]=1 and HREADY=1; the slave captures HADDR[7:2] and HWRITE into address-phase registers.
REQ-015 Register map by HADDR[3:2]: 0=CTRL, 1=COMPARE, 2=COUNT, 3=STATUS; HADDR[1:0] ignored.
REQ-016 CTRL bits: [0] EN, [1] IRQ_EN, [2] ONESHOT, [31:16] PRESC; bits [15:3] read 0, writes ignored.
REQ-017 STATUS bit0 MATCH; write 1 clears, write 0 no effect; bits [31:1] read 0.
REQ-018 OKAY read: zero wait states; HRDATA loaded at the accepting edge with the selected register's value at that edge; HREADY=1, HRESP=0 in the data phase.
REQ-019 OKAY write: zero wait states; HWDATA written into the captured register at the end of the data phase (edge after the data-phase cycle).
REQ-020 Accepted transfer with HADDR[7:4]!=0: two-cycle ERROR response -- cycle 1 HREADY=0 HRESP=1, cycle 2 HREADY=1 HRESP=1; no register written; HRDATA=0.
REQ-021 During ERROR cycle 1, HREADY=0, so no new transfer is accepted; one presented in that cycle is ignored.
REQ-022 IDLE/unselected cycles: HREADY=1, HRESP=0, HRDATA holds its last value.
REQ-023 Back-to-back transfers are allowed: the data phase of transfer N overlaps the address phase of transfer N+1.
REQ-024 Read of a register written by the immediately preceding transfer returns the new value (write-to-read forwarding).
REQ-025 Prescaler: presc_cnt counts 0..PRESC while EN=1; tick when presc_cnt==PRESC, then presc_cnt returns to 0; PRESC=0 gives a tick every cycle.
REQ-026 presc_cnt is cleared when EN=0 and on any write to CTRL.
REQ-027 On a tick: if COUNT==COMPARE, COUNT<=0 and MATCH<=1, and if ONESHOT=1 then EN<=0; otherwise COUNT<=COUNT+1 (32-bit, wraps).
REQ-028 A bus write to COUNT in the same cycle as a tick: the bus write wins; no increment; a match is not evaluated that cycle.
REQ-029 A STATUS write-1-clear in the same cycle as a MATCH set: the set wins (MATCH=1).
REQ-030 irq registered: irq <= MATCH & IRQ_EN (one cycle after MATCH/IRQ_EN change).

Reset
REQ-031 On Rst=1: CTRL=0, COMPARE=RST_COMPARE, COUNT=0, MATCH=0, presc_cnt=0, HRDATA=0, HREADY=1, HRESP=0, irq=0, address-phase registers cleared (no pending data phase).
REQ-032 Rst asserted mid-transfer aborts it; no register write occurs; after release the slave is idle with HREADY=1.

Verification
REQ-033 Write COMPARE=5, CTRL=0x0000_0003 (PRESC=0) -> COUNT reads 0..5, then 0 on the 7th tick, MATCH=1, irq=1 one cycle after MATCH.
REQ-034 CTRL=0x0002_0005 (PRESC=2, ONESHOT) with COMPARE=1 -> COUNT increments every 3 cycles; after the match, EN=0 and COUNT stays 0.
REQ-035 Read HADDR offset 0x40 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1; all registers are unchanged.
REQ-036 Back-to-back write COMPARE=0x1234 then read COMPARE -> the read data phase returns 0x0000_1234 with no wait state.
REQ-037 Force a match in the same cycle as STATUS write 0x1 -> MATCH stays 1; a following write 0x1 clears it and irq drops one cycle later.
REQ-038 Assert Rst during a write data phase to COMPARE -> COMPARE=RST_COMPARE after reset, HREADY=1, irq=0.
